// File: rtl/reaction_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, default sizes and the BCD digit type.
package reaction_pkg;

   localparam int DEF_WIDTH  = 14;
   localparam int DEF_DIGITS = 4;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      FINISH
   } state_t;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
// Purely combinational.
module bcd_add3
   import reaction_pkg::*;
(
   input  bcd_digit_t din,
   output bcd_digit_t dout
);

   assign dout = (din >= 4'd5) ? bcd_digit_t'(din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter; done pulses WIDTH+2 cycles after start is sampled, start ignored while busy.
// Define BIN2BCD_SATURATE_EN to clamp overflowing inputs to all nines (ovf is reported either way).
module bin2bcd_seq
   import reaction_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DIGITS = DEF_DIGITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf
);

   localparam int          BW      = 4 * DIGITS;
   localparam int          CW      = $clog2(WIDTH + 1);
   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

   state_t              state;
   state_t              state_nxt;
   logic [CW-1:0]       cnt;
   logic [BW+WIDTH-1:0] work;
   logic [BW-1:0]       bcd_adj;
   logic                ovf_cap;
   logic                last_shift;

   // BCD digits live above the binary bits so one left shift moves both.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3 u_add3 (
         .din  (work[WIDTH+4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   assign last_shift = (cnt == CW'(1));
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_shift) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work    <= '0;
         cnt     <= '0;
         ovf_cap <= 1'b0;
         done    <= 1'b0;
         bcd_out <= '0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  work    <= {{BW{1'b0}}, bin_in};
                  cnt     <= CW'(WIDTH);
                  ovf_cap <= (64'(bin_in) > MAX_VAL);
               end
            end
            SHIFT: begin
               // The top digit's carry falls off, leaving value mod 10^DIGITS.
               work <= {bcd_adj, work[WIDTH-1:0]} << 1;
               cnt  <= cnt - CW'(1);
            end
            FINISH: begin
               done <= 1'b1;
               ovf  <= ovf_cap;
`ifdef BIN2BCD_SATURATE_EN
               bcd_out <= ovf_cap ? {DIGITS{bcd_digit_t'(4'd9)}} : work[BW+WIDTH-1:WIDTH];
`else
               bcd_out <= work[BW+WIDTH-1:WIDTH];
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
